// File: rtl/ook_frame_encoder.sv
// Byte-to-OOK line encoder: gathers FRAME_BYTES bytes, then sends the frame REPEAT times as
// pulse-width-coded OOK with a sync gap. Optional macro OOK_BYTE_TIMEOUT_EN drops stale partial frames.
module ook_frame_encoder #(
    parameter int CLK_HZ      = 12000000,
    parameter int TE_US       = 350,
    parameter int FRAME_BYTES = 3,
    parameter int REPEAT      = 4,
    parameter int SYNC_TE     = 31,
    parameter int GAP_CYCLES  = 1200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       rf_tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int TE_CYCLES = CLK_HZ / 1000000 * TE_US;
    localparam int NBITS     = 8 * FRAME_BYTES;
    localparam int PH_MAX    = (SYNC_TE > 3) ? SYNC_TE : 3;
    localparam int TE_W      = (TE_CYCLES > 1) ? $clog2(TE_CYCLES) : 1;
    localparam int PH_W      = $clog2(PH_MAX);
    localparam int BI_W      = $clog2(NBITS);
    localparam int REP_W     = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    localparam int BY_W      = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;

    if (FRAME_BYTES < 1 || FRAME_BYTES > 8 || REPEAT < 1 || REPEAT > 15 ||
        TE_CYCLES < 1 || SYNC_TE < 1 || GAP_CYCLES < 2) begin : g_param_check
        $error("ook_frame_encoder: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HIGH   = 3'd1,
        S_LOW    = 3'd2,
        S_SYNC_H = 3'd3,
        S_SYNC_L = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [TE_W-1:0]    r_te_cnt;
    logic [PH_W-1:0]    r_ph_cnt;
    logic [BI_W-1:0]    r_bit_idx;
    logic [REP_W-1:0]   r_rep;
    logic [BY_W-1:0]    r_byte_idx;
    logic [NBITS-1:0]   r_frame;
    logic               r_rf_tx;
    logic               r_frame_done;
    logic [PH_W-1:0]    w_ph_end;
    logic               w_cur_bit;
    logic               w_accept;
    logic               w_last_byte;
    logic               w_last_bit;
    logic               w_last_rep;
    logic               w_te_last;
    logic               w_ph_done;
    logic               w_gap_expire;

    assign in_ready    = (r_state == S_IDLE) & ~rst;
    assign busy        = (r_state != S_IDLE);
    assign rf_tx       = r_rf_tx;
    assign frame_done  = r_frame_done;
    assign w_accept    = in_valid & in_ready;
    assign w_last_byte = (r_byte_idx == BY_W'(FRAME_BYTES - 1));
    assign w_last_bit  = (r_bit_idx == BI_W'(NBITS - 1));
    assign w_last_rep  = (r_rep == REP_W'(REPEAT - 1));
    assign w_te_last   = (r_te_cnt == TE_W'(TE_CYCLES - 1));
    assign w_ph_done   = w_te_last & (r_ph_cnt == w_ph_end);

    // Current data bit, byte 0 first and MSB first within each byte.
    always_comb begin
        w_cur_bit = 1'b0;
        for (int i = 0; i < NBITS; i++) begin
            if (r_bit_idx == BI_W'(i)) begin
                w_cur_bit = r_frame[NBITS-1-i];
            end else begin
                w_cur_bit = w_cur_bit;
            end
        end
    end

    // Last TE index of the current phase: a 1 is 3 TE high / 1 TE low, a 0 the reverse.
    always_comb begin
        w_ph_end = PH_W'(0);
        case (r_state)
            S_HIGH:   w_ph_end = w_cur_bit ? PH_W'(2) : PH_W'(0);
            S_LOW:    w_ph_end = w_cur_bit ? PH_W'(0) : PH_W'(2);
            S_SYNC_L: w_ph_end = PH_W'(SYNC_TE - 1);
            default:  w_ph_end = PH_W'(0);
        endcase
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_last_byte) w_state_nxt = S_HIGH;
                else                         w_state_nxt = S_IDLE;
            end
            S_HIGH: begin
                if (w_ph_done) w_state_nxt = S_LOW;
                else           w_state_nxt = S_HIGH;
            end
            S_LOW: begin
                if (w_ph_done) w_state_nxt = w_last_bit ? S_SYNC_H : S_HIGH;
                else           w_state_nxt = S_LOW;
            end
            S_SYNC_H: begin
                if (w_ph_done) w_state_nxt = S_SYNC_L;
                else           w_state_nxt = S_SYNC_H;
            end
            S_SYNC_L: begin
                if (w_ph_done) w_state_nxt = w_last_rep ? S_IDLE : S_HIGH;
                else           w_state_nxt = S_SYNC_L;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef OOK_BYTE_TIMEOUT_EN
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    logic [GAP_W-1:0] r_gap_cnt;

    assign w_gap_expire = (r_state == S_IDLE) && (r_byte_idx != '0) && !w_accept &&
                          (r_gap_cnt == GAP_W'(GAP_CYCLES - 1));

    // Idle time of a partially filled frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gap_cnt <= '0;
        end else if (w_accept || (r_state != S_IDLE) || (r_byte_idx == '0) || w_gap_expire) begin
            r_gap_cnt <= '0;
        end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
        end
    end
`else
    assign w_gap_expire = 1'b0;
`endif

    // State, timing counters, frame fill and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_te_cnt     <= '0;
            r_ph_cnt     <= '0;
            r_bit_idx    <= '0;
            r_rep        <= '0;
            r_byte_idx   <= '0;
            r_frame      <= '0;
            r_rf_tx      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rf_tx      <= (r_state == S_HIGH) || (r_state == S_SYNC_H);
            r_frame_done <= (r_state == S_SYNC_L) && w_ph_done && w_last_rep;

            if (r_state == S_IDLE) begin
                r_te_cnt <= '0;
                r_ph_cnt <= '0;
            end else if (w_te_last) begin
                r_te_cnt <= '0;
                r_ph_cnt <= w_ph_done ? '0 : r_ph_cnt + 1'b1;
            end else begin
                r_te_cnt <= r_te_cnt + 1'b1;
            end

            if (r_state == S_LOW && w_ph_done && !w_last_bit) begin
                r_bit_idx <= r_bit_idx + 1'b1;
            end else if (r_state == S_SYNC_L && w_ph_done) begin
                r_bit_idx <= '0;
            end else begin
                r_bit_idx <= r_bit_idx;
            end

            if (r_state == S_SYNC_L && w_ph_done) begin
                r_rep <= w_last_rep ? '0 : r_rep + 1'b1;
            end else begin
                r_rep <= r_rep;
            end

            if (w_accept) begin
                r_byte_idx <= w_last_byte ? '0 : r_byte_idx + 1'b1;
                for (int k = 0; k < FRAME_BYTES; k++) begin
                    if (r_byte_idx == BY_W'(k)) r_frame[NBITS-1-8*k -: 8] <= in_data;
                end
            end else if (w_gap_expire) begin
                r_byte_idx <= '0;
            end else begin
                r_byte_idx <= r_byte_idx;
            end
        end
    end

endmodule

// File: tb/tb_ook_frame_encoder.sv
// Self-checking bench for ook_frame_encoder: table-driven frames, hand-written corner sequences
// and random frames, all compared against a per-cycle waveform model built from the coding rules.
module tb_ook_frame_encoder;

    localparam int CLK_HZ     = 1000000;
    localparam int TE_US      = 2;
    localparam int FB         = 2;
    localparam int REPEAT     = 2;
    localparam int SYNC_TE    = 31;
    localparam int GAP_CYCLES = 50;
    localparam int TE         = CLK_HZ / 1000000 * TE_US;
    localparam int REP_LEN    = (32 * FB + 1 + SYNC_TE) * TE;
    localparam int FRAME_LEN  = REPEAT * REP_LEN;
    localparam int EDGES      = REPEAT * (2 * 8 * FB + 2);

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       rf_tx;
    logic       busy;
    logic       frame_done;

    int checks = 0;
    int errors = 0;
    bit exp_q[$];

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        int         high;
    } vec_t;
    vec_t tbl[5];

    ook_frame_encoder #(
        .CLK_HZ(CLK_HZ), .TE_US(TE_US), .FRAME_BYTES(FB),
        .REPEAT(REPEAT), .SYNC_TE(SYNC_TE), .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .rf_tx(rf_tx), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected rf_tx, one entry per cycle, for the whole frame including all repetitions.
    task automatic build_wave(input logic [8*FB-1:0] frame);
        int hi;
        exp_q.delete();
        for (int r = 0; r < REPEAT; r++) begin
            for (int i = 0; i < 8 * FB; i++) begin
                hi = frame[8*FB-1-i] ? 3 : 1;
                repeat (hi * TE) exp_q.push_back(1'b1);
                repeat ((4 - hi) * TE) exp_q.push_back(1'b0);
            end
            repeat (TE) exp_q.push_back(1'b1);
            repeat (SYNC_TE * TE) exp_q.push_back(1'b0);
        end
    endtask

    function automatic int high_cycles(input logic [8*FB-1:0] frame);
        int ones;
        ones = $countones(frame);
        return REPEAT * TE * (3 * ones + (8 * FB - ones) + 1);
    endfunction

    // Drive one byte at a negedge, hold until accepted; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 32'(n < 2000), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Called at the negedge one cycle after the final accept; returns at the frame_done cycle.
    task automatic run_frame(input string tag, input logic [8*FB-1:0] frame, input int exp_high);
        int bad_tx, busy_cnt, done_cnt, rdy_cnt, high_cnt, edges;
        bit prev;
        bad_tx = 0; done_cnt = 0; rdy_cnt = 0; high_cnt = 0; edges = 0; prev = 1'b0;
        build_wave(frame);
        check({tag, "_busy_start"}, 32'(busy), 32'd1);
        check({tag, "_rdy_start"}, 32'(in_ready), 32'd0);
        check({tag, "_tx_start"}, 32'(rf_tx), 32'd0);
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        for (int k = 1; k <= FRAME_LEN; k++) begin
            @(negedge clk);
            if (rf_tx !== exp_q[k-1]) bad_tx++;
            if (rf_tx === 1'b1) high_cnt++;
            if (rf_tx !== prev) edges++;
            prev = rf_tx;
            if (busy === 1'b1) busy_cnt++;
            if (frame_done === 1'b1) done_cnt++;
            if (in_ready !== 1'b0 && k < FRAME_LEN) rdy_cnt++;
        end
        check({tag, "_wave_mismatches"}, 32'(bad_tx), 32'd0);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(FRAME_LEN));
        check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        check({tag, "_done_end"}, 32'(frame_done), 32'd1);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_rdy_end"}, 32'(in_ready), 32'd1);
        check({tag, "_rdy_while_busy"}, 32'(rdy_cnt), 32'd0);
        check({tag, "_edges"}, 32'(edges), 32'(EDGES));
        check({tag, "_high_cycles"}, 32'(high_cnt), 32'(exp_high));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [7:0] rb0, rb1;

        tbl[0] = '{8'hA5, 8'h0F, 132};
        tbl[1] = '{8'hFF, 8'h00, 132};
        tbl[2] = '{8'h00, 8'h00, 68};
        tbl[3] = '{8'hFF, 8'hFF, 196};
        tbl[4] = '{8'h80, 8'h01, 84};

        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_rf_tx", 32'(rf_tx), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_rdy_during", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_rdy_after", 32'(in_ready), 32'd1);
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            send_byte(tbl[v].b0);
            send_byte(tbl[v].b1);
            run_frame($sformatf("tbl%0d", v), {tbl[v].b0, tbl[v].b1}, tbl[v].high);
        end

        // Byte held during transmission is taken on the frame_done cycle.
        send_byte(8'hA5);
        send_byte(8'h0F);
        in_valid = 1'b1;
        in_data  = 8'h55;
        run_frame("hold", {8'hA5, 8'h0F}, 132);
        @(posedge clk);
        @(negedge clk);
        check("hold_busy_after_first", 32'(busy), 32'd0);
        send_byte(8'h3C);
        run_frame("hold_next", {8'h55, 8'h3C}, 132);

        // Reset in the middle of a HIGH phase of the second repetition.
        send_byte(8'hA5);
        send_byte(8'h0F);
        repeat (194) @(negedge clk);
        check("mid_rst_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_rf_tx", 32'(rf_tx), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rdy", 32'(in_ready), 32'd1);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (frame_done !== 1'b0 || rf_tx !== 1'b0 || busy !== 1'b0) cnt++;
        end
        check("mid_rst_quiet", 32'(cnt), 32'd0);
        send_byte(8'h12);
        send_byte(8'h34);
        run_frame("post_rst", {8'h12, 8'h34}, 108);

        // Partial frame followed by a long idle gap.
        send_byte(8'hC3);
        repeat (GAP_CYCLES) @(negedge clk);
        check("gap_busy", 32'(busy), 32'd0);
`ifdef OOK_BYTE_TIMEOUT_EN
        send_byte(8'h12);
        send_byte(8'h34);
        run_frame("gap", {8'h12, 8'h34}, 108);
`else
        send_byte(8'h12);
        run_frame("gap", {8'hC3, 8'h12}, 116);
`endif

        for (int r = 0; r < 4; r++) begin
            rb0 = 8'($urandom_range(0, 255));
            rb1 = 8'($urandom_range(0, 255));
            send_byte(rb0);
            send_byte(rb1);
            run_frame($sformatf("rnd%0d", r), {rb0, rb1}, high_cycles({rb0, rb1}));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
